mux8_scan_ctrl: RTL and testbench

//   Upstream/downstream companion of the 8:1 mux stage: drives the mux's 3-bit select,

---
 rtl/mux8_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_ctrl.sv
// Scan controller for an 8:1 mux: steps sel through all channels,
// waits SETTLE cycles per channel, samples Y and emits one 8-bit word per scan.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, cont           begin a scan (IDLE only) / auto-restart at completion
//   sel, mux_y            mux select out, mux output in
//   busy                  scan in progress
//   data, data_valid      assembled word (data[k] = sample at sel==k) + valid
//   data_ready            consumer accept
//   overrun               sticky: unconsumed word overwritten
module mux8_scan_ctrl #(
  parameter int unsigned SETTLE    = 2,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  output logic [2:0] sel,
  input  logic       mux_y,
  output logic       busy,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [2:0] FIRST   = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST    = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [3:0] CNT_MAX = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;

  logic [7:0] acc_merged;

  always_comb begin
    acc_merged        = acc_q;
    acc_merged[sel_q] = mux_y;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;

    // Accept first; a completion below on the same edge re-asserts valid.
    if (valid_q && data_ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_d  = 3'd0;
        busy_d = 1'b0;
        if (start) begin
          state_d = SCAN;
          busy_d  = 1'b1;
          ovr_d   = 1'b0;
          sel_d   = FIRST;
          cnt_d   = 4'd0;
          acc_d   = 8'h00;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = 4'd0;
          acc_d = acc_merged;
          if (sel_q == LAST) begin
            data_d  = acc_merged;
            valid_d = 1'b1;
            if (valid_q && !data_ready) ovr_d = 1'b1;
            acc_d = 8'h00;
            if (cont) begin
              sel_d = FIRST;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              sel_d   = 3'd0;
            end
          end else begin
            sel_d = MSB_FIRST ? sel_q - 3'd1 : sel_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= 4'd0;
      acc_q   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: three instances cover
// SETTLE=2 LSB-first, SETTLE=2 MSB-first and SETTLE=1.
module tb_mux8_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] pat = 8'h00;

  logic [2:0] s0, s1, s2;
  logic       y0, y1, y2;
  logic       b0, b1, b2;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       o0, o1, o2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign y0 = pat[s0];
  assign y1 = pat[s1];
  assign y2 = pat[s2];

  mux8_scan_ctrl #(.SETTLE(2), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .sel(s0), .mux_y(y0), .busy(b0), .data(d0),
    .data_valid(v0), .data_ready(ready), .overrun(o0)
  );

  mux8_scan_ctrl #(.SETTLE(2), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .sel(s1), .mux_y(y1), .busy(b1), .data(d1),
    .data_valid(v1), .data_ready(ready), .overrun(o1)
  );

  mux8_scan_ctrl #(.SETTLE(1), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .sel(s2), .mux_y(y2), .busy(b2), .data(d2),
    .data_valid(v2), .data_ready(ready), .overrun(o2)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    cont = 1'b0;
    ready = 1'b1;
    do_reset();
    chk("rst_sel", {5'd0, s0}, 8'd0);
    chk("rst_busy", {7'd0, b0}, 8'd0);
    chk("rst_data", d0, 8'h00);
    chk("rst_valid", {7'd0, v0}, 8'd0);
    chk("rst_ovr", {7'd0, o0}, 8'd0);

    // 1: SETTLE=2 LSB first, single shot
    pat = 8'hA5;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t1_busy0", {7'd0, b0}, 8'd1);
    chk("t1_sel0", {5'd0, s0}, 8'd0);
    for (int i = 1; i < 16; i++) begin
      step(1);
      chk("t1_sel", {5'd0, s0}, 8'(i / 2));
    end
    step(1);
    chk("t1_data", d0, 8'hA5);
    chk("t1_valid", {7'd0, v0}, 8'd1);
    chk("t1_busy", {7'd0, b0}, 8'd0);
    chk("t1_sel_end", {5'd0, s0}, 8'd0);
    step(1);
    chk("t1_accept", {7'd0, v0}, 8'd0);

    // 2: MSB first, bit mapping unchanged
    do_reset();
    pat = 8'h3C;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t2_sel0", {5'd0, s1}, 8'd7);
    for (int i = 1; i < 16; i++) begin
      step(1);
      chk("t2_sel", {5'd0, s1}, 8'(7 - i / 2));
    end
    step(1);
    chk("t2_data", d1, 8'h3C);
    chk("t2_valid", {7'd0, v1}, 8'd1);
    chk("t2_busy", {7'd0, b1}, 8'd0);

    // 3: continuous, no consumer -> overrun
    do_reset();
    cont = 1'b1;
    ready = 1'b0;
    pat = 8'h0F;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(15);
    chk("t3_valid_pre", {7'd0, v0}, 8'd0);
    step(1);
    chk("t3_data1", d0, 8'h0F);
    chk("t3_ovr1", {7'd0, o0}, 8'd0);
    chk("t3_busy1", {7'd0, b0}, 8'd1);
    chk("t3_sel1", {5'd0, s0}, 8'd0);
    pat = 8'hF0;
    step(16);
    chk("t3_data2", d0, 8'hF0);
    chk("t3_ovr2", {7'd0, o0}, 8'd1);
    chk("t3_valid2", {7'd0, v0}, 8'd1);
    cont = 1'b0;
    step(16);
    chk("t3_idle", {7'd0, b0}, 8'd0);
    chk("t3_ovr_hold", {7'd0, o0}, 8'd1);
    step(3);
    chk("t3_ovr_idle", {7'd0, o0}, 8'd1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t3_ovr_clr", {7'd0, o0}, 8'd0);
    chk("t3_restart", {7'd0, b0}, 8'd1);

    // 4: accept exactly on completion edge
    do_reset();
    cont = 1'b1;
    ready = 1'b0;
    pat = 8'h55;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(16);
    chk("t4_data1", d0, 8'h55);
    pat = 8'h33;
    step(15);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("t4_valid", {7'd0, v0}, 8'd1);
    chk("t4_data2", d0, 8'h33);
    chk("t4_ovr", {7'd0, o0}, 8'd0);
    cont = 1'b0;

    // 5: reset mid-scan after 5 samples, then clean scan
    do_reset();
    ready = 1'b1;
    pat = 8'hFF;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(10);
    chk("t5_sel_mid", {5'd0, s0}, 8'd5);
    rst_n = 1'b0;
    step(1);
    chk("t5_sel", {5'd0, s0}, 8'd0);
    chk("t5_busy", {7'd0, b0}, 8'd0);
    chk("t5_data", d0, 8'h00);
    chk("t5_valid", {7'd0, v0}, 8'd0);
    chk("t5_ovr", {7'd0, o0}, 8'd0);
    rst_n = 1'b1;
    pat = 8'h12;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(16);
    chk("t5_word", d0, 8'h12);
    chk("t5_wvalid", {7'd0, v0}, 8'd1);

    // 6: SETTLE=1, start held while busy
    do_reset();
    cont = 1'b0;
    ready = 1'b1;
    pat = 8'hC3;
    start = 1'b1;
    step(1);
    chk("t6_busy0", {7'd0, b2}, 8'd1);
    for (int i = 1; i < 8; i++) begin
      step(1);
      chk("t6_sel", {5'd0, s2}, 8'(i));
    end
    step(1);
    start = 1'b0;
    chk("t6_data", d2, 8'hC3);
    chk("t6_busy_end", {7'd0, b2}, 8'd0);
    step(4);
    chk("t6_stay_idle", {7'd0, b2}, 8'd0);
    chk("t6_consumed", {7'd0, v2}, 8'd0);

    // 6b: SETTLE=1 continuous, one word every 8 cycles
    do_reset();
    cont = 1'b1;
    ready = 1'b0;
    pat = 8'h96;
    start = 1'b1;
    step(1);
    step(7);
    chk("t6b_valid_pre", {7'd0, v2}, 8'd0);
    step(1);
    chk("t6b_data1", d2, 8'h96);
    chk("t6b_busy", {7'd0, b2}, 8'd1);
    pat = 8'h5A;
    step(8);
    chk("t6b_data2", d2, 8'h5A);
    chk("t6b_ovr", {7'd0, o2}, 8'd1);
    start = 1'b0;
    cont = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
